int2float_sched: RTL and testbench

INT2FLOAT_SCHED -- requirements
Module: int2float_sched

---
 rtl/int2float_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/int2float_sched.sv | 106 ++++++++++
 tb/tb_int2float_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int2float_pkg.sv
// rtl/int2float_pkg.sv - shared widths and result-register state for int2float_sched
//   IN_W_DEF  : default integer operand width
//   OUT_W_DEF : default float result width
//   state_e   : result register state, value equals rsp_valid
package int2float_pkg;

  localparam int IN_W_DEF  = 11;
  localparam int OUT_W_DEF = 7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts at ptr and wraps
//   req_i       : request vector
//   ptr_i       : highest-priority index this cycle
//   grant_o     : one-hot grant, zero when no request
//   grant_idx_o : index of the granted request (0 when none)
//   any_o       : a request was granted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDW:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!any_o && req_i[cand[IDW-1:0]]) begin
        any_o                   = 1'b1;
        grant_idx_o             = cand[IDW-1:0];
        grant_o[cand[IDW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int2float_sched.sv
// rtl/int2float_sched.sv - shares one external int2float converter among NREQ requesters
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_data   : packed operands, requester i at [i*IN_W +: IN_W]
//   req_ready  : one-hot-or-zero accept strobe
//   cvt_in     : operand to the external converter
//   cvt_res    : converter result, combinational from cvt_in
//   rsp_valid, rsp_data, rsp_id, rsp_ready : registered result handshake
//   done_cnt   : completed conversions, saturating
module int2float_sched
  import int2float_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IN_W-1:0]      cvt_in,
  input  logic [OUT_W-1:0]     cvt_res,
  output logic                 rsp_valid,
  output logic [OUT_W-1:0]     rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic [15:0]          done_cnt
);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [15:0]        done_cnt_q, done_cnt_d;

  logic               can_issue;
  logic [NREQ-1:0]    arb_req;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_grant;

  // Reset gates issue so nothing is accepted while the result is being discarded.
  assign can_issue = !rst && ((state_q == ST_EMPTY) || rsp_ready);
  assign arb_req   = req_valid & {NREQ{can_issue}};

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i       (arb_req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_grant)
  );

  assign req_ready = grant;
  assign cvt_in    = any_grant ? req_data[int'(grant_idx)*IN_W +: IN_W] : '0;

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    done_cnt_d = done_cnt_q;

    if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
      if (done_cnt_q != 16'hFFFF) begin
        done_cnt_d = done_cnt_q + 16'd1;
      end
    end

    // A grant in the same cycle as a drain overwrites the slot, keeping one result per cycle.
    if (any_grant) begin
      state_d    = ST_FULL;
      rsp_data_d = cvt_res;
      rsp_id_d   = grant_idx;
      ptr_d      = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_int2float_sched.sv
// tb/tb_int2float_sched.sv - self-checking bench for int2float_sched
module tb_int2float_sched;

  localparam int NREQ  = 4;
  localparam int IN_W  = 11;
  localparam int OUT_W = 7;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      cvt_in;
  logic [OUT_W-1:0]     cvt_res;
  logic                 rsp_valid;
  logic [OUT_W-1:0]     rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic [15:0]          done_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int2float_sched #(
    .NREQ  (NREQ),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cvt_in    (cvt_in),
    .cvt_res   (cvt_res),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  // Golden converter: 3-bit exponent (leading-one position, clamped) and 4 mantissa bits.
  function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] x);
    int msb;
    int e;
    int m;
    msb = -1;
    for (int i = 0; i < IN_W; i++) if (x[i]) msb = i;
    if (msb < 0) return '0;
    e = (msb > 7) ? 7 : msb;
    if (msb >= 4) m = (int'(x) >> (msb - 4)) & 15;
    else          m = (int'(x) << (4 - msb)) & 15;
    return {e[2:0], m[3:0]};
  endfunction

  always_comb cvt_res = golden(cvt_in);

  function automatic logic [IN_W-1:0] slice(input int i);
    return req_data[i*IN_W +: IN_W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; checks happen at the following falling edge.
  task automatic step(input logic [NREQ-1:0] rv, input logic rr);
    @(posedge clk);
    #1;
    req_valid = rv;
    rsp_ready = rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [IN_W-1:0] dat [NREQ];

  task automatic load_fixed();
    for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = dat[i];
  endtask

  typedef struct {
    logic [NREQ-1:0] rv;
    logic            rr;
    logic [NREQ-1:0] rdy;
    logic            vld;
    logic [IDW-1:0]  id;
    logic [15:0]     done;
  } vec_t;

  vec_t tbl [9];

  typedef struct {
    int               id;
    logic [OUT_W-1:0] d;
  } ent_t;

  ent_t mq [$];
  int   m_ptr;
  int   m_cnt;

  initial begin
    dat[0] = 11'd5;
    dat[1] = 11'd300;
    dat[2] = 11'd0;
    dat[3] = 11'd2047;

    tbl[0] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd0};
    tbl[2] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 16'd1};
    tbl[3] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 16'd1};
    tbl[4] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd2};
    tbl[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'd2};
    tbl[6] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 16'd2};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 16'd3};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd4};

    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    load_fixed();

    // Reset state, with requests present to show req_ready is held low.
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_done_cnt",  32'(done_cnt),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cvt_in",    32'(cvt_in),    32'd0);
    do_reset();

    // Directed table: single requester, wrap of ptr, back-pressure, drain+grant.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rv, tbl[i].rr);
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_rsp_id", i),   32'(rsp_id),   32'(tbl[i].id));
        chk($sformatf("tbl%0d_rsp_data", i), 32'(rsp_data), 32'(golden(dat[tbl[i].id])));
      end
      chk($sformatf("tbl%0d_done_cnt", i), 32'(done_cnt), 32'(tbl[i].done));
    end

    // All four requesting: strict 0,1,2,3 rotation, one result per cycle.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1);
      chk($sformatf("rot%0d_req_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
      chk($sformatf("rot%0d_cvt_in", k), 32'(cvt_in), 32'(dat[k % 4]));
      if (k > 0) begin
        chk($sformatf("rot%0d_rsp_id", k),   32'(rsp_id),   32'((k - 1) % 4));
        chk($sformatf("rot%0d_rsp_data", k), 32'(rsp_data), 32'(golden(dat[(k - 1) % 4])));
      end
    end
    step(4'b0000, 1'b1);
    chk("rot_last_id", 32'(rsp_id), 32'd3);
    step(4'b0000, 1'b1);
    chk("rot_done_cnt", 32'(done_cnt), 32'd8);

    // Five cycles of back-pressure, then drain and new grant together.
    do_reset();
    step(4'b0001, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0);
      chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_id", k),    32'(rsp_id),    32'd0);
      chk($sformatf("bp%0d_rsp_data", k),  32'(rsp_data),  32'(golden(dat[0])));
    end
    step(4'b1111, 1'b1);
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    step(4'b0000, 1'b1);
    chk("bp_new_valid", 32'(rsp_valid), 32'd1);
    chk("bp_new_id",    32'(rsp_id),    32'd1);
    chk("bp_new_data",  32'(rsp_data),  32'(golden(dat[1])));

    // Reset while FULL with ptr=2: result discarded, priority back to requester 0.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    chk("rf_pre_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rf_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rf_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rf_done_cnt",  32'(done_cnt),  32'd0);
    chk("rf_req_ready", 32'(req_ready), 32'b0001);

    // Counter saturation at 16'hFFFF.
    do_reset();
    @(negedge clk);
    force dut.done_cnt_q = 16'hFFFE;
    #1;
    release dut.done_cnt_q;
    chk("sat_preload", 32'(done_cnt), 32'hFFFE);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    chk("sat_before", 32'(done_cnt), 32'hFFFE);
    step(4'b0001, 1'b1);
    chk("sat_hit", 32'(done_cnt), 32'hFFFF);
    step(4'b0000, 1'b1);
    chk("sat_hold1", 32'(done_cnt), 32'hFFFF);
    step(4'b0000, 1'b1);
    chk("sat_hold2", 32'(done_cnt), 32'hFFFF);
    chk("sat_empty", 32'(rsp_valid), 32'd0);

    // Randomized traffic against a queue-based reference.
    do_reset();
    mq.delete();
    m_ptr = 0;
    m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] rv;
      logic            rr;
      int              g;
      logic [NREQ-1:0] exp_rdy;
      rv = NREQ'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = IN_W'($urandom);
      req_valid = rv;
      rsp_ready = rr;
      @(negedge clk);

      g = -1;
      if (mq.size() == 0 || rr) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);

      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_cvt_in", 32'(cvt_in), (g < 0) ? 32'd0 : 32'(slice(g)));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rnd_rsp_id",   32'(rsp_id),   32'(mq[0].id));
        chk("rnd_rsp_data", 32'(rsp_data), 32'(mq[0].d));
      end
      chk("rnd_done_cnt", 32'(done_cnt), 32'(m_cnt));

      if (mq.size() != 0 && rr) begin
        void'(mq.pop_front());
        if (m_cnt < 16'hFFFF) m_cnt++;
      end
      if (g >= 0) begin
        mq.push_back('{g, golden(slice(g))});
        m_ptr = (g + 1) % NREQ;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
